noc_merge_arb2: RTL and testbench

Clocked two-input merge arbiter for the NoC packet fabric: combines two 9-bit packet streams into one output link, the converse of the leaf decoder's split. Round-robin arbitration between inputs, one-entry registered output stage, and a select flag reporting which input each output packet came from. Sits at every router output port where two decoder branches converge.

---
 rtl/noc_pkg.sv | 16 +
 rtl/rr_arb2.sv | 31 +++
 rtl/noc_merge_arb2.sv | 99 +++++++++
 tb/tb_noc_merge_arb2.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC packet definitions: packet layout, statistics width and output-stage states.
package noc_pkg;

  localparam int PKT_W   = 9;
  localparam int ADDR_HI = 8;
  localparam int ADDR_LO = 5;
  localparam int STAT_W  = 16;

  typedef logic [PKT_W-1:0] pkt_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } ostate_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin arbiter; last_grant only moves when a granted request transfers.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  // Resets to 1 so input 0 wins the first contention.
  logic last_grant_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_reg <= 1'b1;
    end else if (advance) begin
      last_grant_reg <= grant[1];
    end
  end

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant_reg ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/noc_merge_arb2.sv
// Two-input round-robin merge onto one link with a one-entry registered output stage.
// Optional per-input grant counters are built when NOC_ARB_STATS_EN is defined.
module noc_merge_arb2
  import noc_pkg::*;
#(
  parameter int W = PKT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in0_valid,
  output logic         in0_ready,
  input  logic [W-1:0] in0_data,
  input  logic         in1_valid,
  output logic         in1_ready,
  input  logic [W-1:0] in1_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_sel
`ifdef NOC_ARB_STATS_EN
  ,
  input  logic              stats_clr,
  output logic [STAT_W-1:0] grant_cnt0,
  output logic [STAT_W-1:0] grant_cnt1
`endif
);

  ostate_t      state_reg, state_next;
  logic [W-1:0] out_data_reg;
  logic         out_sel_reg;
  logic [1:0]   grant;
  logic [1:0]   xfer_vec;
  logic         load_en;
  logic         xfer;

  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     ({in1_valid, in0_valid}),
    .advance (xfer),
    .grant   (grant)
  );

  assign out_valid = (state_reg == ST_FULL);
  assign load_en   = !out_valid || out_ready;
  // Readys are held low during reset so nothing transfers on the reset edge.
  assign in0_ready = load_en && grant[0] && !reset;
  assign in1_ready = load_en && grant[1] && !reset;
  assign xfer_vec  = {in1_valid && in1_ready, in0_valid && in0_ready};
  assign xfer      = |xfer_vec;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_EMPTY: if (xfer) state_next = ST_FULL;
      ST_FULL:  if (out_ready && !xfer) state_next = ST_EMPTY;
      default:  state_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_reg <= '0;
      out_sel_reg  <= 1'b0;
    end else if (xfer) begin
      out_data_reg <= grant[1] ? in1_data : in0_data;
      out_sel_reg  <= grant[1];
    end
  end

  assign out_data = out_data_reg;
  assign out_sel  = out_sel_reg;

`ifdef NOC_ARB_STATS_EN
  // Clear wins over a same-cycle increment; counts saturate at all-ones.
  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    logic [STAT_W-1:0] cnt_reg;
    always_ff @(posedge clk) begin
      if (reset || stats_clr) begin
        cnt_reg <= '0;
      end else if (xfer_vec[gi] && (cnt_reg != {STAT_W{1'b1}})) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign grant_cnt0 = g_cnt[0].cnt_reg;
  assign grant_cnt1 = g_cnt[1].cnt_reg;
`endif

endmodule

// File: tb/tb_noc_merge_arb2.sv
// Directed table-driven bench for noc_merge_arb2 plus short hand-written sequences.
module tb_noc_merge_arb2;

  logic       clk;
  logic       reset;
  logic       in0_valid, in0_ready;
  logic [8:0] in0_data;
  logic       in1_valid, in1_ready;
  logic [8:0] in1_data;
  logic       out_valid, out_ready;
  logic [8:0] out_data;
  logic       out_sel;
`ifdef NOC_ARB_STATS_EN
  logic        stats_clr;
  logic [15:0] grant_cnt0, grant_cnt1;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  noc_merge_arb2 dut (
    .clk       (clk),
    .reset     (reset),
    .in0_valid (in0_valid),
    .in0_ready (in0_ready),
    .in0_data  (in0_data),
    .in1_valid (in1_valid),
    .in1_ready (in1_ready),
    .in1_data  (in1_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel)
`ifdef NOC_ARB_STATS_EN
    ,
    .stats_clr  (stats_clr),
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       v0;
    logic [8:0] d0;
    logic       v1;
    logic [8:0] d1;
    logic       ordy;
    logic       e_r0;
    logic       e_r1;
    logic       e_ov;
    logic [8:0] e_data;
    logic       e_sel;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  task automatic check(input string name, input int idx, input logic [15:0] got,
                       input logic [15:0] exp);
    total_cnt++;
    if (got === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s step %0d: got %h expected %h", name, idx, got, exp);
    end
  endtask

  // Drive in1 alone with out_ready high until accepted, then check the output register.
  task automatic send1(input logic [8:0] d, input int idx);
    bit got_it;
    got_it = 1'b0;
    @(negedge clk);
    in0_valid = 1'b0;
    in1_valid = 1'b1;
    in1_data  = d;
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (in1_ready) begin
        got_it = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("in1_accept", idx, {15'd0, got_it}, 16'd1);
    @(posedge clk);
    #1;
    check("seq_out_data", idx, {7'd0, out_data}, {7'd0, d});
    check("seq_out_sel", idx, {15'd0, out_sel}, 16'd1);
    $display("seq %0d: in1 data=%h -> out_valid=%b out_data=%h out_sel=%b",
             idx, d, out_valid, out_data, out_sel);
  endtask

  initial begin
    reset     = 1'b1;
    in0_valid = 1'b0;
    in0_data  = '0;
    in1_valid = 1'b0;
    in1_data  = '0;
    out_ready = 1'b0;
`ifdef NOC_ARB_STATS_EN
    stats_clr = 1'b0;
`endif

    //          rst v0  d0       v1  d1      ordy r0  r1  ov  data     sel
    vecs[0]  = '{1, 1, 9'h1A5, 0, 9'h000, 1,  0, 0, 0, 9'h000, 0};
    vecs[1]  = '{0, 1, 9'h1A5, 0, 9'h000, 1,  1, 0, 1, 9'h1A5, 0};
    vecs[2]  = '{0, 0, 9'h000, 0, 9'h000, 1,  0, 0, 0, 9'h1A5, 0};
    vecs[3]  = '{1, 0, 9'h000, 0, 9'h000, 1,  0, 0, 0, 9'h000, 0};
    vecs[4]  = '{0, 1, 9'h100, 1, 9'h0FF, 1,  1, 0, 1, 9'h100, 0};
    vecs[5]  = '{0, 1, 9'h100, 1, 9'h0FF, 1,  0, 1, 1, 9'h0FF, 1};
    vecs[6]  = '{0, 1, 9'h100, 1, 9'h0FF, 1,  1, 0, 1, 9'h100, 0};
    vecs[7]  = '{0, 1, 9'h100, 1, 9'h0FF, 1,  0, 1, 1, 9'h0FF, 1};
    vecs[8]  = '{0, 1, 9'h033, 1, 9'h0FF, 1,  1, 0, 1, 9'h033, 0};
    vecs[9]  = '{0, 1, 9'h100, 1, 9'h0FF, 0,  0, 0, 1, 9'h033, 0};
    vecs[10] = '{0, 1, 9'h100, 1, 9'h0FF, 0,  0, 0, 1, 9'h033, 0};
    vecs[11] = '{0, 1, 9'h100, 1, 9'h0FF, 0,  0, 0, 1, 9'h033, 0};
    vecs[12] = '{0, 1, 9'h100, 1, 9'h0FF, 1,  0, 1, 1, 9'h0FF, 1};
    vecs[13] = '{1, 1, 9'h100, 1, 9'h0FF, 0,  0, 0, 0, 9'h000, 0};
    vecs[14] = '{0, 1, 9'h100, 1, 9'h0FF, 1,  1, 0, 1, 9'h100, 0};
    vecs[15] = '{0, 0, 9'h000, 1, 9'h0FF, 0,  0, 0, 1, 9'h100, 0};
    vecs[16] = '{0, 0, 9'h000, 0, 9'h000, 0,  0, 0, 1, 9'h100, 0};
    vecs[17] = '{0, 0, 9'h000, 0, 9'h000, 1,  0, 0, 0, 9'h100, 0};
    vecs[18] = '{0, 1, 9'h100, 1, 9'h0FF, 1,  0, 1, 1, 9'h0FF, 1};
    vecs[19] = '{0, 1, 9'h0A5, 0, 9'h000, 0,  0, 0, 1, 9'h0FF, 1};
    vecs[20] = '{0, 1, 9'h0A5, 0, 9'h000, 1,  1, 0, 1, 9'h0A5, 0};
    vecs[21] = '{0, 0, 9'h000, 0, 9'h000, 1,  0, 0, 0, 9'h0A5, 0};

    repeat (2) @(posedge clk);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      reset     = vecs[i].rst;
      in0_valid = vecs[i].v0;
      in0_data  = vecs[i].d0;
      in1_valid = vecs[i].v1;
      in1_data  = vecs[i].d1;
      out_ready = vecs[i].ordy;
      #1;
      check("in0_ready", i, {15'd0, in0_ready}, {15'd0, vecs[i].e_r0});
      check("in1_ready", i, {15'd0, in1_ready}, {15'd0, vecs[i].e_r1});
      @(posedge clk);
      #1;
      check("out_valid", i, {15'd0, out_valid}, {15'd0, vecs[i].e_ov});
      check("out_data", i, {7'd0, out_data}, {7'd0, vecs[i].e_data});
      check("out_sel", i, {15'd0, out_sel}, {15'd0, vecs[i].e_sel});
      $display("vec %0d: rst=%b v0=%b v1=%b ordy=%b -> r0=%b r1=%b ov=%b data=%h sel=%b",
               i, vecs[i].rst, vecs[i].v0, vecs[i].v1, vecs[i].ordy,
               vecs[i].e_r0, vecs[i].e_r1, out_valid, out_data, out_sel);
    end

    send1(9'h011, 0);
    send1(9'h122, 1);
    send1(9'h0EE, 2);

`ifdef NOC_ARB_STATS_EN
    @(negedge clk);
    in1_valid = 1'b0;
    stats_clr = 1'b1;
    @(posedge clk);
    #1;
    check("cnt0_clr", 0, grant_cnt0, 16'd0);
    check("cnt1_clr", 0, grant_cnt1, 16'd0);
    @(negedge clk);
    stats_clr = 1'b0;
    for (int k = 0; k < 5; k++) send1(9'h040 + 9'(k), 10 + k);
    @(negedge clk);
    in1_valid = 1'b0;
    #1;
    check("cnt1_five", 0, grant_cnt1, 16'd5);
    check("cnt0_zero", 0, grant_cnt0, 16'd0);
    $display("stats: cnt0=%0d cnt1=%0d", grant_cnt0, grant_cnt1);
    in1_valid = 1'b1;
    in1_data  = 9'h055;
    out_ready = 1'b1;
    stats_clr = 1'b1;
    #1;
    check("clr_xfer_ready", 0, {15'd0, in1_ready}, 16'd1);
    @(posedge clk);
    #1;
    check("cnt1_clr_win", 0, grant_cnt1, 16'd0);
    check("clr_xfer_data", 0, {7'd0, out_data}, 16'h0055);
    $display("stats clr with grant: cnt1=%0d", grant_cnt1);
    @(negedge clk);
    stats_clr = 1'b0;
`endif

    @(negedge clk);
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
